dmem_bist: RTL and testbench

DMEM_BIST -- requirements
Module: dmem_bist

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/dmem_bist_if.sv | 13 +
 rtl/mem_watchdog.sv | 34 +++
 rtl/dmem_bist.sv | 143 ++++++++++++++
 tb/tb_dmem_bist.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types, defaults and the test-pattern generator for the data-memory BIST.
package mips_mem_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} bist_state_e;

   localparam int TIMEOUT_DEF  = 255;
   localparam int MAXWORDS_DEF = 64;

   // Pattern for word i of a run: seed + i, wrapping at 32 bits.
   function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [7:0] idx);
      return seed + {24'b0, idx};
   endfunction

endpackage

// File: rtl/dmem_bist_if.sv
// Data-memory bus between the BIST engine (master) and the memory (slave).
interface dmem_bist_if;

   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        MemReady;

   modport master (output memwrite, dataadr, writedata, input readdata, MemReady);
   modport slave  (input memwrite, dataadr, writedata, output readdata, MemReady);

endinterface

// File: rtl/mem_watchdog.sv
// Per-access cycle counter; expired rises once TIMEOUT cycles have passed since clear.
module mem_watchdog
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 2);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q >= W'(TIMEOUT));

   // Saturates at TIMEOUT so a long stall never wraps back to "not expired".
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (tick && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dmem_bist.sv
// Data-memory BIST: writes seed+i over a word region, reads it back and reports
// mismatches, first failing address and per-access MemReady timeouts.
module dmem_bist
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT  = TIMEOUT_DEF,
   parameter int MAXWORDS = MAXWORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] base_adr,
   input  logic [7:0]  word_count,
   input  logic [31:0] seed,
   dmem_bist_if.master mem,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [7:0]  err_count,
   output logic [31:0] fail_adr
);

   localparam logic [7:0] MAX_CNT = 8'(MAXWORDS);

   bist_state_e state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [7:0]  count_q, count_d;
   logic [31:0] seed_q, seed_d;
   logic [7:0]  idx_q, idx_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  err_q, err_d;
   logic [31:0] fail_q, fail_d;

   logic [31:0] cur_adr, cur_pat;
   logic        last, wd_expired;

   assign cur_adr = base_q + {22'b0, idx_q, 2'b00};
   assign cur_pat = pattern(seed_q, idx_q);
   assign last    = (idx_q == count_q - 8'd1);

   assign busy          = (state_q == WRITE) || (state_q == READ);
   assign done          = (state_q == DONE);
   assign mem.memwrite  = (state_q == WRITE);
   assign mem.dataadr   = busy ? cur_adr : '0;
   assign mem.writedata = (state_q == WRITE) ? cur_pat : '0;

   assign pass      = pass_q;
   assign timeout   = timeout_q;
   assign err_count = err_q;
   assign fail_adr  = fail_q;

   // Watchdog restarts whenever an access completes and stays cleared outside a run.
   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .reset   (reset),
      .clear   (!busy || mem.MemReady),
      .tick    (busy),
      .expired (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      count_d   = count_q;
      seed_d    = seed_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      err_d     = err_q;
      fail_d    = fail_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d    = base_adr & 32'hFFFF_FFFC;
               count_d   = word_count;
               seed_d    = seed;
               idx_d     = '0;
               err_d     = '0;
               timeout_d = 1'b0;
               fail_d    = '0;
               if (word_count == 8'd0 || word_count > MAX_CNT) begin
                  state_d = DONE;
                  pass_d  = (word_count == 8'd0);
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE, READ: begin
            if (mem.MemReady) begin
               if (state_q == READ && mem.readdata != cur_pat) begin
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  if (err_q == 8'd0)  fail_d = cur_adr;
               end
               if (!last) begin
                  idx_d = idx_q + 8'd1;
               end else if (state_q == WRITE) begin
                  state_d = READ;
                  idx_d   = '0;
               end else begin
                  state_d = DONE;
                  pass_d  = (err_d == 8'd0) && !timeout_q;
               end
            end else if (wd_expired) begin
               // Abort; fail_adr keeps an earlier mismatch address if one exists.
               timeout_d = 1'b1;
               if (err_q == 8'd0) fail_d = cur_adr;
               pass_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         count_q   <= '0;
         seed_q    <= '0;
         idx_q     <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         err_q     <= '0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         count_q   <= count_d;
         seed_q    <= seed_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         fail_q    <= fail_d;
      end
   end

endmodule

// File: tb/tb_dmem_bist.sv
// Directed bench for dmem_bist: a memory responder pops expected accesses from a
// scoreboard queue and checks each one as MemReady completes it.
module tb_dmem_bist;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_adr = '0;
   logic [7:0]  word_count = '0;
   logic [31:0] seed = '0;
   logic        busy, done, pass, timeout;
   logic [7:0]  err_count;
   logic [31:0] fail_adr;

   dmem_bist_if bus ();

   dmem_bist dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_adr   (base_adr),
      .word_count (word_count),
      .seed       (seed),
      .mem        (bus),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout),
      .err_count  (err_count),
      .fail_adr   (fail_adr)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          rsp_delay = 0;
   bit          rsp_off = 1'b0;
   bit          saw_wr = 1'b0;
   logic [31:0] corrupt_adr = 32'hFFFF_FFFF;
   logic [31:0] mem_arr [0:255];
   acc_t        exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Queue the write pass then the read pass of a run.
   task automatic push_run(input logic [31:0] base, input int cnt, input logic [31:0] sd);
      logic [31:0] b;
      b = base & 32'hFFFF_FFFC;
      for (int i = 0; i < cnt; i++) exp_q.push_back('{1'b1, b + 32'(4 * i), sd + 32'(i)});
      for (int i = 0; i < cnt; i++) exp_q.push_back('{1'b0, b + 32'(4 * i), 32'h0});
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [7:0] cnt, input logic [31:0] sd);
      @(posedge clk); #1;
      start = 1'b1; base_adr = base; word_count = cnt; seed = sd;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // cyc = edges after the start-sampling edge until done is visible.
   task automatic run(input logic [31:0] base, input logic [7:0] cnt, input logic [31:0] sd,
                      input bit push, output int cyc);
      if (push) push_run(base, int'(cnt), sd);
      pulse_start(base, cnt, sd);
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   // Memory responder: completes accesses after rsp_delay wait cycles.
   initial begin
      acc_t e;
      int   wait_cnt;
      wait_cnt = 0;
      bus.MemReady = 1'b0;
      bus.readdata = '0;
      forever begin
         @(negedge clk);
         bus.MemReady = 1'b0;
         bus.readdata = '0;
         if (bus.memwrite) saw_wr = 1'b1;
         if (busy && !reset && !rsp_off) begin
            if (wait_cnt >= rsp_delay) begin
               wait_cnt = 0;
               bus.MemReady = 1'b1;
               checks++;
               assert (exp_q.size() != 0) else begin
                  errors++;
                  $error("FAIL sb_empty: observed access at 0x%0h, expected none", bus.dataadr);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("acc_we", 32'(bus.memwrite), 32'(e.we));
                  chk("acc_adr", bus.dataadr, e.adr);
                  chk("acc_wdata", bus.writedata, e.dat);
               end
               if (bus.memwrite) mem_arr[bus.dataadr[9:2]] = bus.writedata;
               else bus.readdata = (bus.dataadr == corrupt_adr) ? 32'h0000_DEAD
                                                                : mem_arr[bus.dataadr[9:2]];
            end else begin
               wait_cnt++;
               if (exp_q.size() != 0) begin
                  chk("hold_we", 32'(bus.memwrite), 32'(exp_q[0].we));
                  chk("hold_adr", bus.dataadr, exp_q[0].adr);
                  chk("hold_wdata", bus.writedata, exp_q[0].dat);
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      int cyc;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_memwrite", 32'(bus.memwrite), 32'd0);
      chk("rst_dataadr", bus.dataadr, 32'h0);
      chk("rst_wdata", bus.writedata, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_fail", fail_adr, 32'h0);
      reset = 1'b0;

      // Clean run, MemReady every cycle: 4 writes + 4 reads.
      run(32'h40, 8'd4, 32'h100, 1'b1, cyc);
      chk("t1_cycles", 32'(cyc), 32'd8);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_err", 32'(err_count), 32'd0);
      chk("t1_timeout", 32'(timeout), 32'd0);
      chk("t1_sb_left", 32'(exp_q.size()), 32'd0);

      // Word 2 reads back corrupted.
      corrupt_adr = 32'h48;
      run(32'h40, 8'd4, 32'h100, 1'b1, cyc);
      corrupt_adr = 32'hFFFF_FFFF;
      chk("t2_cycles", 32'(cyc), 32'd8);
      chk("t2_pass", 32'(pass), 32'd0);
      chk("t2_err", 32'(err_count), 32'd1);
      chk("t2_fail", fail_adr, 32'h48);
      chk("t2_timeout", 32'(timeout), 32'd0);

      // Three wait cycles per access, unaligned base, seed wrapping past zero.
      rsp_delay = 3;
      run(32'h203, 8'd4, 32'hFFFF_FFFE, 1'b1, cyc);
      rsp_delay = 0;
      chk("t3_cycles", 32'(cyc), 32'd32);
      chk("t3_pass", 32'(pass), 32'd1);
      chk("t3_err", 32'(err_count), 32'd0);
      chk("t3_fail", fail_adr, 32'h0);
      chk("t3_sb_left", 32'(exp_q.size()), 32'd0);

      // No MemReady at all: watchdog aborts the first write.
      rsp_off = 1'b1;
      run(32'h80, 8'd3, 32'h5, 1'b0, cyc);
      rsp_off = 1'b0;
      chk("t4_cycles", 32'(cyc), 32'd256);
      chk("t4_timeout", 32'(timeout), 32'd1);
      chk("t4_pass", 32'(pass), 32'd0);
      chk("t4_fail", fail_adr, 32'h80);
      chk("t4_err", 32'(err_count), 32'd0);

      // Zero words: straight to DONE, no writes, stale timeout cleared.
      saw_wr = 1'b0;
      run(32'h10, 8'd0, 32'h0, 1'b0, cyc);
      chk("t5_cycles", 32'(cyc), 32'd0);
      chk("t5_pass", 32'(pass), 32'd1);
      chk("t5_timeout", 32'(timeout), 32'd0);
      chk("t5_fail", fail_adr, 32'h0);
      chk("t5_no_write", 32'(saw_wr), 32'd0);

      // One word above the limit is rejected.
      run(32'h10, 8'd65, 32'h0, 1'b0, cyc);
      chk("t6_cycles", 32'(cyc), 32'd0);
      chk("t6_pass", 32'(pass), 32'd0);
      chk("t6_no_write", 32'(saw_wr), 32'd0);

      // Good run so pass is 1, then reset in the middle of the read pass.
      run(32'h100, 8'd2, 32'h7, 1'b1, cyc);
      chk("t7_pass", 32'(pass), 32'd1);
      push_run(32'h40, 4, 32'h100);
      pulse_start(32'h40, 8'd4, 32'h100);
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("t7_read_busy", 32'(busy), 32'd1);
      chk("t7_read_nowr", 32'(bus.memwrite), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t7_memwrite", 32'(bus.memwrite), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_done", 32'(done), 32'd0);
      chk("t7_pass0", 32'(pass), 32'd0);
      chk("t7_dataadr", bus.dataadr, 32'h0);
      chk("t7_wdata", bus.writedata, 32'h0);
      chk("t7_err", 32'(err_count), 32'd0);
      chk("t7_fail", fail_adr, 32'h0);
      reset = 1'b0;
      exp_q.delete();

      // Fresh run after the abort behaves normally.
      run(32'h40, 8'd4, 32'h100, 1'b1, cyc);
      chk("t8_cycles", 32'(cyc), 32'd8);
      chk("t8_pass", 32'(pass), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
